// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALU selects, branch and M-extension
// funct3 codes, forwarding selects and the iterative mul/div state machine.
package execute_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_muldiv_if.sv
// ID/EX inputs, EX/MEM outputs and the redirect/stall signals of the execute stage.
interface execute_muldiv_if #(
  parameter int XLEN = 32
) ();

  logic            regwriteE, memrwE, branchE, jumpE, jalrE, bselE, mdopE, flushE;
  logic [1:0]      wbselE;
  logic [2:0]      funct3E;
  logic [3:0]      ALUselE;
  logic [1:0]      forwardAE, forwardBE;
  logic [4:0]      rdE;
  logic [XLEN-1:0] rd1E, rd2E, imm_exE, pcE, pc4E, resultW;

  logic            pcselE;
  logic [XLEN-1:0] pcTargetE;
  logic            busyE;

  logic            regwriteM, memrwM;
  logic [1:0]      wbselM;
  logic [4:0]      rdM;
  logic [XLEN-1:0] ALUresM, data_writeM, pc4M;

  modport slave (
    input  regwriteE, memrwE, branchE, jumpE, jalrE, bselE, mdopE, flushE,
           wbselE, funct3E, ALUselE, forwardAE, forwardBE, rdE,
           rd1E, rd2E, imm_exE, pcE, pc4E, resultW,
    output pcselE, pcTargetE, busyE,
           regwriteM, memrwM, wbselM, rdM, ALUresM, data_writeM, pc4M
  );

  modport master (
    output regwriteE, memrwE, branchE, jumpE, jalrE, bselE, mdopE, flushE,
           wbselE, funct3E, ALUselE, forwardAE, forwardBE, rdE,
           rd1E, rd2E, imm_exE, pcE, pc4E, resultW,
    input  pcselE, pcTargetE, busyE,
           regwriteM, memrwM, wbselM, rdM, ALUresM, data_writeM, pc4M
  );

endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider working on operand magnitudes;
// signs are re-applied to the result while in DONE.
module muldiv_iter
  import execute_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, dividend_q, dividend_d;
  md_op_e          op_q, op_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
  end

  // hi:lo is the product accumulator for multiply and remainder:quotient for divide
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, mcand_q};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mcand_d    = mcand_q;
    dividend_d = dividend_q;
    op_d       = op_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    div0_d     = div0_q;
    case (state_q)
      MD_IDLE: begin
        if (start && !abort) begin
          state_d    = MD_RUN;
          cnt_d      = '0;
          hi_d       = '0;
          lo_d       = a_mag;
          mcand_d    = b_mag;
          dividend_d = a;
          op_d       = op;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          div0_d     = (b == '0);
        end
      end
      MD_RUN: begin
        if (abort) begin
          state_d = MD_IDLE;
        end else begin
          if (op_q[2]) begin
            if (!div_trial[XLEN]) begin
              hi_d = div_trial[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_shift[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == LAST) state_d = MD_DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      dividend_q <= '0;
      op_q       <= MD_MUL;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mcand_q    <= mcand_d;
      dividend_q <= dividend_d;
      op_q       <= op_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      div0_q     <= div0_d;
    end
  end

  assign busy = !abort && (((state_q == MD_IDLE) && start) || (state_q == MD_RUN));
  assign done = !abort && (state_q == MD_DONE);

  // Divide-by-zero bypasses sign fix-up; MIN/-1 falls out of the magnitude path
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = qneg_q ? -prod : prod;
    result   = '0;
    case (op_q)
      MD_MUL:                       result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result = div0_q ? '1 : (qneg_q ? -lo_q : lo_q);
      MD_REM, MD_REMU:              result = div0_q ? dividend_q : (rneg_q ? -hi_q : hi_q);
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: forwarding, ALU, branch resolution, optional iterative M unit
// and the EX/MEM pipeline register.
module execute_muldiv
  import execute_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input logic              clk,
  input logic              rst,
  execute_muldiv_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, rs2_fwd, src_b, alu_res, ex_res, md_res;
  logic [SHW-1:0]  shamt;
  logic            br_cond, md_busy, md_done, md_start;

  logic            regwrite_q, regwrite_d, memrw_q, memrw_d;
  logic [1:0]      wbsel_q, wbsel_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] alu_res_q, alu_res_d, data_write_q, data_write_d, pc4_q, pc4_d;

  always_comb begin
    case (bus.forwardAE)
      FWD_RF:  src_a = bus.rd1E;
      FWD_WB:  src_a = bus.resultW;
      FWD_MEM: src_a = alu_res_q;
      default: src_a = '0;
    endcase
    case (bus.forwardBE)
      FWD_RF:  rs2_fwd = bus.rd2E;
      FWD_WB:  rs2_fwd = bus.resultW;
      FWD_MEM: rs2_fwd = alu_res_q;
      default: rs2_fwd = '0;
    endcase
    src_b = bus.bselE ? bus.imm_exE : rs2_fwd;
    shamt = src_b[SHW-1:0];
  end

  always_comb begin
    case (bus.ALUselE)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      default:  alu_res = '0;
    endcase
  end

  // Branches compare the two register operands, never the immediate
  always_comb begin
    case (bus.funct3E)
      BR_EQ:   br_cond = (src_a == rs2_fwd);
      BR_NE:   br_cond = (src_a != rs2_fwd);
      BR_LT:   br_cond = ($signed(src_a) <  $signed(rs2_fwd));
      BR_GE:   br_cond = ($signed(src_a) >= $signed(rs2_fwd));
      BR_LTU:  br_cond = (src_a <  rs2_fwd);
      BR_GEU:  br_cond = (src_a >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  assign md_start = bus.mdopE & ~bus.flushE;

  generate
    if (MD_EN != 0) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .abort  (bus.flushE),
        .op     (md_op_e'(bus.funct3E)),
        .a      (src_a),
        .b      (rs2_fwd),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
      );
    end else begin : g_no_md
      assign md_busy = 1'b0;
      assign md_done = 1'b0;
      assign md_res  = '0;
    end
  endgenerate

  assign ex_res        = md_done ? md_res : alu_res;
  assign bus.busyE     = md_busy;
  assign bus.pcselE    = ((bus.branchE & br_cond) | bus.jumpE) & ~md_busy;
  assign bus.pcTargetE = bus.jalrE ? ((src_a + bus.imm_exE) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                   : (bus.pcE + bus.imm_exE);

  // Stalls and flushes insert a bubble: controls cleared, data fields held
  always_comb begin
    regwrite_d   = bus.regwriteE;
    memrw_d      = bus.memrwE;
    wbsel_d      = bus.wbselE;
    rd_d         = bus.rdE;
    alu_res_d    = ex_res;
    data_write_d = rs2_fwd;
    pc4_d        = bus.pc4E;
    if (bus.flushE || md_busy) begin
      regwrite_d   = 1'b0;
      memrw_d      = 1'b0;
      wbsel_d      = 2'b00;
      rd_d         = 5'd0;
      alu_res_d    = alu_res_q;
      data_write_d = data_write_q;
      pc4_d        = pc4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      memrw_q      <= 1'b0;
      wbsel_q      <= 2'b00;
      rd_q         <= 5'd0;
      alu_res_q    <= '0;
      data_write_q <= '0;
      pc4_q        <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      memrw_q      <= memrw_d;
      wbsel_q      <= wbsel_d;
      rd_q         <= rd_d;
      alu_res_q    <= alu_res_d;
      data_write_q <= data_write_d;
      pc4_q        <= pc4_d;
    end
  end

  assign bus.regwriteM   = regwrite_q;
  assign bus.memrwM      = memrw_q;
  assign bus.wbselM      = wbsel_q;
  assign bus.rdM         = rd_q;
  assign bus.ALUresM     = alu_res_q;
  assign bus.data_writeM = data_write_q;
  assign bus.pc4M        = pc4_q;

endmodule
